// File: rtl/bird_collision_detector.sv
// Frame-based bird collision detector: accumulates bird/target overlaps per frame and
// reports per-bird hit pulses at start of frame. Optional hold-off: COLLISION_HOLDOFF_EN.
module bird_collision_detector #(
    parameter int HOLDOFF_FRAMES = 4,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               birdDR,
    input  logic [1:0]         birdSel,
    input  logic               pigDR,
    input  logic               blockDR,
    input  logic               groundDR,
    input  logic               clearScore,
    output logic [1:0]         hitPig,
    output logic [1:0]         hitBlock,
    output logic [1:0]         hitGround,
    output logic               collisionAny,
    output logic [SCORE_W-1:0] pigHits
);

    // Target index within a per-bird vector: 0 pig, 1 block, 2 ground.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SUPP   = 2'd2
    } acc_state_e;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_FRAMES);

    logic [2:0]         ovl_s;
    logic [1:0]         bird_s;
    logic [1:0]         contact_s;
    logic [1:0][2:0]    acc_q, acc_d;
    logic [1:0][2:0]    rep_s;
    logic [1:0]         rep_any_s;
    logic [1:0]         gate_s;
    logic [1:0]         hold_last_s;
    acc_state_e         state_q [2];
    acc_state_e         state_d [2];
    acc_state_e         report_state_s;
    logic [1:0]         hit_pig_q, hit_pig_d;
    logic [1:0]         hit_block_q, hit_block_d;
    logic [1:0]         hit_ground_q, hit_ground_d;
    logic               coll_any_q, coll_any_d;
    logic [SCORE_W-1:0] score_q, score_d;

    // Per-pixel overlap and one-hot effective bird (bird 1 wins when both selected)
    always_comb begin
        ovl_s  = {groundDR, blockDR, pigDR} & {3{birdDR}};
        bird_s = 2'b00;
        if (!birdDR) begin
            bird_s = 2'b00;
        end else if (birdSel[0]) begin
            bird_s = 2'b01;
        end else if (birdSel[1]) begin
            bird_s = 2'b10;
        end else begin
            bird_s = 2'b00;
        end
        contact_s = bird_s & {2{|ovl_s}};
    end

    // Reported set per bird: closing-frame accumulation plus this cycle's overlap, gated
    always_comb begin
        rep_s     = '0;
        rep_any_s = 2'b00;
        for (int b = 0; b < 2; b++) begin
            rep_s[b]     = (acc_q[b] | (ovl_s & {3{bird_s[b]}})) & {3{gate_s[b]}};
            rep_any_s[b] = |rep_s[b];
        end
    end

    // Frame accumulators: cleared at every frame boundary, set on overlap otherwise
    always_comb begin
        acc_d = acc_q;
        if (startOfFrame) begin
            acc_d = '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                acc_d[b] = acc_q[b] | (ovl_s & {3{bird_s[b]}});
            end
        end
    end

`ifdef COLLISION_HOLDOFF_EN
    logic [1:0][3:0] hold_q, hold_d;

    // Hold-off counters: reload on report, otherwise count down once per frame
    always_comb begin
        hold_d = hold_q;
        for (int b = 0; b < 2; b++) begin
            if (!startOfFrame) begin
                hold_d[b] = hold_q[b];
            end else if (rep_any_s[b]) begin
                hold_d[b] = HOLD_LOAD;
            end else if (hold_q[b] != 4'd0) begin
                hold_d[b] = hold_q[b] - 4'd1;
            end else begin
                hold_d[b] = hold_q[b];
            end
            hold_last_s[b] = (hold_q[b] == 4'd1);
        end
        report_state_s = ST_SUPP;
    end

    // Hold-off counter registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_cfg_s;

    // Without hold-off a reporting bird returns straight to IDLE
    always_comb begin
        hold_last_s    = 2'b00;
        report_state_s = ST_IDLE;
        unused_cfg_s   = ^HOLD_LOAD;
    end
`endif

    // Accumulator state registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= ST_IDLE;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    // Accumulator next-state logic
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                ST_IDLE, ST_ARMED: begin
                    if (startOfFrame) begin
                        state_d[b] = rep_any_s[b] ? report_state_s : ST_IDLE;
                    end else if (contact_s[b]) begin
                        state_d[b] = ST_ARMED;
                    end else begin
                        state_d[b] = state_q[b];
                    end
                end
                ST_SUPP: begin
                    if (startOfFrame && hold_last_s[b]) begin
                        state_d[b] = ST_IDLE;
                    end else begin
                        state_d[b] = ST_SUPP;
                    end
                end
                default: state_d[b] = ST_IDLE;
            endcase
        end
    end

    // A suppressed bird contributes nothing to the report
    always_comb begin
        gate_s = 2'b11;
        for (int b = 0; b < 2; b++) begin
            gate_s[b] = (state_q[b] != ST_SUPP);
        end
    end

    // Pulse outputs, pixel strobe and saturating pig-hit score
    always_comb begin
        hit_pig_d    = 2'b00;
        hit_block_d  = 2'b00;
        hit_ground_d = 2'b00;
        if (startOfFrame) begin
            hit_pig_d    = {rep_s[1][0], rep_s[0][0]};
            hit_block_d  = {rep_s[1][1], rep_s[0][1]};
            hit_ground_d = {rep_s[1][2], rep_s[0][2]};
        end else begin
            hit_pig_d    = 2'b00;
            hit_block_d  = 2'b00;
            hit_ground_d = 2'b00;
        end
        coll_any_d = (|bird_s) & (pigDR | blockDR | groundDR);
        score_d    = score_q;
        if (clearScore) begin
            score_d = '0;
        end else if ((|hit_pig_d) && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
            score_d = score_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q        <= '0;
            hit_pig_q    <= 2'b00;
            hit_block_q  <= 2'b00;
            hit_ground_q <= 2'b00;
            coll_any_q   <= 1'b0;
            score_q      <= '0;
        end else begin
            acc_q        <= acc_d;
            hit_pig_q    <= hit_pig_d;
            hit_block_q  <= hit_block_d;
            hit_ground_q <= hit_ground_d;
            coll_any_q   <= coll_any_d;
            score_q      <= score_d;
        end
    end

    assign hitPig       = hit_pig_q;
    assign hitBlock     = hit_block_q;
    assign hitGround    = hit_ground_q;
    assign collisionAny = coll_any_q;
    assign pigHits      = score_q;

endmodule

// File: tb/tb_bird_collision_detector.sv
// Self-checking bench for bird_collision_detector: directed vector table, hand-written
// hold-off/saturation sequences and randomized frames against a frame-level model.
module tb_bird_collision_detector;

    localparam int HOLD = 4;
`ifdef COLLISION_HOLDOFF_EN
    localparam bit HO_EN = 1'b1;
`else
    localparam bit HO_EN = 1'b0;
`endif
    localparam int PERIOD = HO_EN ? HOLD + 1 : 1;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0, birdDR = 1'b0;
    logic [1:0] birdSel = 2'b00;
    logic       pigDR = 1'b0, blockDR = 1'b0, groundDR = 1'b0, clearScore = 1'b0;
    logic [1:0] hitPig, hitBlock, hitGround;
    logic       collisionAny;
    logic [7:0] pigHits;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_model = 1'b0;

    bird_collision_detector #(.HOLDOFF_FRAMES(HOLD), .SCORE_W(8)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .birdDR(birdDR),
        .birdSel(birdSel), .pigDR(pigDR), .blockDR(blockDR), .groundDR(groundDR),
        .clearScore(clearScore), .hitPig(hitPig), .hitBlock(hitBlock),
        .hitGround(hitGround), .collisionAny(collisionAny), .pigHits(pigHits)
    );

    always #5 clk = ~clk;

    // Frame-level reference model
    bit         macc [2][3];
    int         mhold [2];
    int         mscore;
    logic [1:0] e_hp, e_hb, e_hg;
    logic       e_coll;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 3; t++) macc[k][t] = 1'b0;
            mhold[k] = 0;
        end
        mscore = 0; e_hp = 2'b00; e_hb = 2'b00; e_hg = 2'b00; e_coll = 1'b0;
    endtask

    task automatic model_tick(input bit sof, dr, input logic [1:0] sel, input bit pig, blk, gnd, clr);
        bit ov [3];
        bit rep [2][3];
        int cb;
        bit any;
        ov[0] = dr & pig; ov[1] = dr & blk; ov[2] = dr & gnd;
        cb = -1;
        if (dr) begin
            if (sel[0]) cb = 0;
            else if (sel[1]) cb = 1;
        end
        e_coll = (cb >= 0) && (pig || blk || gnd);
        e_hp = 2'b00; e_hb = 2'b00; e_hg = 2'b00;
        if (sof) begin
            for (int k = 0; k < 2; k++) begin
                any = 1'b0;
                for (int t = 0; t < 3; t++) begin
                    rep[k][t] = (macc[k][t] || (cb == k && ov[t])) && (mhold[k] == 0);
                    any |= rep[k][t];
                    macc[k][t] = 1'b0;
                end
                e_hp[k] = rep[k][0]; e_hb[k] = rep[k][1]; e_hg[k] = rep[k][2];
                if (HO_EN && any) mhold[k] = HOLD;
                else if (mhold[k] > 0) mhold[k] = mhold[k] - 1;
            end
        end else if (cb >= 0) begin
            for (int t = 0; t < 3; t++) macc[cb][t] |= ov[t];
        end
        if (clr) mscore = 0;
        else if (e_hp != 2'b00 && mscore < 255) mscore = mscore + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] outs();
        return {hitPig, hitBlock, hitGround, collisionAny, pigHits};
    endfunction

    task automatic step(input bit rst, sof, dr, input logic [1:0] sel, input bit pig, blk, gnd, clr);
        logic [7:0] ms;
        startOfFrame = sof; birdDR = dr; birdSel = sel;
        pigDR = pig; blockDR = blk; groundDR = gnd; clearScore = clr;
        if (rst) resetN = 1'b0;
        @(posedge clk);
        if (rst) model_reset();
        else model_tick(sof, dr, sel, pig, blk, gnd, clr);
        #1;
        ms = 8'(mscore);
        if (cmp_model) chk("model", 32'(outs()), 32'({e_hp, e_hb, e_hg, e_coll, ms}));
        if (rst) resetN = 1'b1;
    endtask

    typedef struct {
        bit rst, sof, dr; logic [1:0] sel; bit pig, blk, gnd, clr;
        logic [1:0] hp, hb, hg; bit coll; logic [7:0] score;
    } vec_t;

    function automatic vec_t mk(bit rst, sof, dr, logic [1:0] sel, bit pig, blk, gnd, clr,
                                logic [1:0] hp, hb, hg, bit coll, logic [7:0] score);
        vec_t v;
        v.rst = rst; v.sof = sof; v.dr = dr; v.sel = sel; v.pig = pig; v.blk = blk;
        v.gnd = gnd; v.clr = clr; v.hp = hp; v.hb = hb; v.hg = hg; v.coll = coll; v.score = score;
        return v;
    endfunction

    vec_t tbl [23];

    initial begin
        logic [1:0] exp_hg;
        // rst sof dr sel pig blk gnd clr | hp hb hg coll score
        tbl[0]  = mk(1,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[1]  = mk(0,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[2]  = mk(0,1,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[3]  = mk(0,0,1,2'b01,1,0,0,0, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[4]  = mk(0,0,1,2'b01,1,0,0,0, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[5]  = mk(0,0,1,2'b01,1,0,0,0, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[6]  = mk(0,0,0,2'b01,1,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[7]  = mk(0,1,0,2'b00,0,0,0,0, 2'b01,2'b00,2'b00,0,8'd1);
        tbl[8]  = mk(0,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd1);
        tbl[9]  = mk(1,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[10] = mk(0,0,1,2'b11,0,1,0,0, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[11] = mk(0,1,0,2'b00,0,0,0,0, 2'b00,2'b01,2'b00,0,8'd0);
        tbl[12] = mk(1,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[13] = mk(0,1,1,2'b10,0,0,1,0, 2'b00,2'b00,2'b10,1,8'd0);
        tbl[14] = mk(0,1,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[15] = mk(0,0,1,2'b00,1,1,1,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[16] = mk(0,1,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[17] = mk(0,0,1,2'b01,1,0,0,0, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[18] = mk(1,0,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[19] = mk(0,1,0,2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,8'd0);
        tbl[20] = mk(0,0,1,2'b10,1,0,0,1, 2'b00,2'b00,2'b00,1,8'd0);
        tbl[21] = mk(0,1,0,2'b00,0,0,0,0, 2'b10,2'b00,2'b00,0,8'd1);
        tbl[22] = mk(0,0,1,2'b10,1,0,0,1, 2'b00,2'b00,2'b00,1,8'd0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].sof, tbl[i].dr, tbl[i].sel, tbl[i].pig, tbl[i].blk,
                 tbl[i].gnd, tbl[i].clr);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].hp, tbl[i].hb, tbl[i].hg, tbl[i].coll, tbl[i].score}));
        end

        cmp_model = 1'b1;

        // Continuous bird 2 ground contact over six frames
        step(1,0,0,2'b00,0,0,0,0);
        for (int f = 1; f <= 6; f++) begin
            repeat (3) step(0,0,1,2'b10,0,0,1,0);
            step(0,1,1,2'b10,0,0,1,0);
            exp_hg = (!HO_EN || f == 1 || f == 6) ? 2'b10 : 2'b00;
            chk($sformatf("holdoff_f%0d", f), 32'(hitGround), 32'(exp_hg));
        end

        // Score saturation and clear-vs-increment priority
        step(1,0,0,2'b00,0,0,0,0);
        for (int i = 0; i < 255 * PERIOD; i++) step(0,1,1,2'b01,1,0,0,0);
        chk("sat_255", 32'(pigHits), 32'd255);
        step(0,1,1,2'b01,1,0,0,0);
        chk("sat_hold", 32'({hitPig, pigHits}), 32'({2'b01, 8'd255}));
        for (int i = 0; i < PERIOD - 1; i++) step(0,1,1,2'b01,1,0,0,0);
        step(0,1,1,2'b01,1,0,0,1);
        chk("clr_hit", 32'({hitPig, pigHits}), 32'({2'b01, 8'd0}));

        // Randomized frames against the model
        step(1,0,0,2'b00,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bird_collision_detector.md
# bird_collision_detector

Frame-based collision detector sitting directly downstream of the bird bitmap stage in the VGA object pipeline. Each pixel cycle it combines the bird's registered drawing request and per-bird select (`enroll_collision`) with the drawing requests of the pig, block and ground layers. It accumulates overlaps over one video frame and, at start of frame, emits one-cycle hit pulses per bird and per target. An optional per-bird hold-off suppresses repeated reports while a bird stays in contact, and a saturating counter tracks pig hits for the score logic.

## Interface
Parameters:
- `HOLDOFF_FRAMES`, 4: frames a bird's reports stay suppressed after it reports a hit; legal range 1..15.
- `SCORE_W`, 8: width of the pig-hit counter.

Ports:
- `clk`  in  1  system pixel clock.
- `resetN`  in  1  asynchronous active-low reset.
- `startOfFrame`  in  1  one-cycle pulse marking the frame boundary.
- `birdDR`  in  1  bird drawing request from the bitmap stage, registered.
- `birdSel`  in  2  per-bird select from the bitmap stage (`enroll_collision`): bit0 is bird 1, bit1 is bird 2.
- `pigDR`  in  1  pig drawing request, cycle-aligned with `birdDR`.
- `blockDR`  in  1  block drawing request, cycle-aligned.
- `groundDR`  in  1  ground/border drawing request, cycle-aligned.
- `clearScore`  in  1  synchronous clear of `pigHits`.
- `hitPig`  out  2  per-bird one-cycle pulse.
- `hitBlock`  out  2  per-bird one-cycle pulse.
- `hitGround`  out  2  per-bird one-cycle pulse.
- `collisionAny`  out  1  registered pixel-level strobe: any bird pixel overlapping any target this cycle.
- `pigHits`  out  `SCORE_W`  saturating count of reported pig hits.

## Operation
- Effective bird: `b = birdSel[0] ? 0 : (birdSel[1] ? 1 : none)`. If both bits are set, bird 1 wins. If `birdDR`=0, there is no bird pixel.
- Per-pixel overlap:
  - pig overlap = `birdDR & pigDR`; block and ground are formed the same way.
  - On overlap, set the frame accumulator `acc{Pig,Block,Ground}[b]`.
- `collisionAny` <= `birdDR & (birdSel!=0) & (pigDR|blockDR|groundDR)`, registered, with one cycle of latency.
- Frame boundary, on the `startOfFrame` cycle:
  - Overlaps present on that same cycle are included in the closing frame.
  - Each bird's reported set is the accumulator OR'd with the current-cycle overlap, gated by `holdoff[b]==0`.
  - Outputs are driven high for exactly the next cycle only.
  - All accumulators are cleared on that same edge.
- Hold-off, per bird:
  - When a bird reports any hit, `holdoff[b]` <= `HOLDOFF_FRAMES`.
  - Otherwise, a nonzero `holdoff[b]` decrements once per `startOfFrame`.
  - A suppressed frame neither reports nor reloads the counter.
- Score:
  - `pigHits` increments by 1 for each `startOfFrame` on which `hitPig` will be nonzero.
  - It increments by 1 even when both birds hit the pig in the same frame.
  - It saturates at all-ones.
  - `clearScore` has priority over increment and zeroes the counter.
- Accumulator states per bird: IDLE (no contact this frame), ARMED (contact seen), SUPPRESSED (`holdoff`≠0).
  - IDLE→ARMED on overlap.
  - ARMED→SUPPRESSED at `startOfFrame`.
  - SUPPRESSED→IDLE when `holdoff` reaches 0 at a frame boundary.

## Timing
- Reset values: all outputs 0, all accumulators 0, `holdoff` 0.
- Reset mid-frame discards any pending accumulation; no pulse is emitted.
- Latency from the `startOfFrame` cycle to the hit pulses is 1 cycle; pulse width is 1 cycle.
- Back-to-back `startOfFrame` pulses are each a full, possibly empty, frame.
- `clearScore` and an increment in the same cycle: the result is 0.

## Configuration
- `COLLISION_HOLDOFF_EN` defined:
  - Hold-off counters and gating are present as described.
- Not defined:
  - No hold-off logic is compiled in.
  - Every frame with contact reports, and `pigHits` counts every such frame.
  - `HOLDOFF_FRAMES` is ignored.

## Test plan
- Reset, then one frame with no overlaps -> all pulses 0, `pigHits`=0.
- Bird 1 (`birdSel`=01) overlaps `pigDR` for 3 pixels, then `startOfFrame` -> `hitPig`=01 for one cycle, `pigHits`=1, `collisionAny` high 3 cycles, each 1 cycle after its overlap.
- `birdSel`=11 with `blockDR` overlap -> `hitBlock`=01 only.
- Overlap asserted only on the `startOfFrame` cycle -> reported in that boundary's pulse; the next frame is empty.
- Hold-off enabled, `HOLDOFF_FRAMES`=4, continuous bird 2 ground contact for 6 frames -> `hitGround`=10 at frames 1 and 6 only. Without the macro -> all 6 frames.
- `pigHits` preset to 255 by 255 hits, then one more hit -> stays 255. `clearScore` on the same cycle as a hit -> 0.
